// File: rtl/uart_tx_fifo_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the configurable UART TX path.
//               tx_state_e - transmitter FSM states
//               DEFAULT_BAUD_DIV - divisor software programs out of reset
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam int unsigned DEFAULT_BAUD_DIV = 16;

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo_cfg_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo_cfg_if
// Description : Valid/ready byte handshake into the UART TX FIFO.
//               tx_data  - byte to queue
//               tx_valid - tx_data holds a byte
//               tx_ready - FIFO can accept a byte this cycle
//               master: producer side, slave: transmitter side
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_fifo_cfg_if #(
  parameter int DW = 8
);
  import uart_pkg::*;

  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;

  modport master (output tx_data, output tx_valid, input  tx_ready);
  modport slave  (input  tx_data, input  tx_valid, output tx_ready);

endinterface
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_sync_fifo
// Description : Single-clock FIFO with show-ahead head (data_o is the oldest
//               entry whenever empty_o=0). Pushes while full and pops while
//               empty are ignored. Count is kept separately from the pointers
//               so full and empty never alias.
//   clk_i, rst_ni       - clock, asynchronous active-low reset
//   push_i, data_i      - write request and data
//   pop_i,  data_o      - read request and head data
//   count_o, full_o, empty_o - occupancy status
// Revision    : 1.0 - initial release
// ============================================================================
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [DW-1:0] data_i,
  input  logic          pop_i,
  output logic [DW-1:0] data_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo_cfg.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo_cfg
// Description : UART transmitter with TX FIFO and per-frame configuration
//               (baud divisor, data bits, parity, stop bits). Frames are sent
//               LSB-first and back-to-back while the FIFO holds data.
//   clk_i, rst_ni  - clock, asynchronous active-low reset
//   en_i           - block enable; low aborts any frame in flight
//   baud_div_i     - cycles per bit (0 behaves as 1)
//   data_bits_i    - data bits per frame (0 or >DW behaves as DW)
//   parity_en_i, parity_odd_i, two_stop_i - frame format
//   tx_if          - valid/ready byte input (slave modport)
//   tx_o           - registered serial line, idle high
//   busy_o         - a frame is being transmitted
//   fifo_count_o, fifo_full_o, fifo_empty_o - FIFO status
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo_cfg
  import uart_pkg::*;
#(
  parameter int DW         = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16,
  parameter int CW         = $clog2(FIFO_DEPTH + 1),
  parameter int NBW        = $clog2(DW + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic [DIV_W-1:0]     baud_div_i,
  input  logic [NBW-1:0]       data_bits_i,
  input  logic                 parity_en_i,
  input  logic                 parity_odd_i,
  input  logic                 two_stop_i,
  uart_tx_fifo_cfg_if.slave    tx_if,
  output logic                 tx_o,
  output logic                 busy_o,
  output logic [CW-1:0]        fifo_count_o,
  output logic                 fifo_full_o,
  output logic                 fifo_empty_o
);

  tx_state_e        state_q, state_d;
  logic [DIV_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [DIV_W-1:0] div_last_q, div_last_d;   // latched divisor minus one
  logic [NBW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [NBW-1:0]   nbits_q, nbits_d;
  logic [DW-1:0]    shift_q, shift_d;
  logic             parity_q, parity_d;       // running XOR of sent data bits
  logic             par_en_q, par_en_d;
  logic             par_odd_q, par_odd_d;
  logic             two_stop_q, two_stop_d;
  logic             tx_q, tx_d;

  logic [DW-1:0]    fifo_head;
  logic [DW-1:0]    shift_nxt;
  logic [DIV_W-1:0] div_last_cfg;
  logic [NBW-1:0]   nbits_cfg;
  logic             pop, load, bit_end, last_data, can_start;

  uart_sync_fifo #(
    .DW    (DW),
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (tx_if.tx_valid),
    .data_i  (tx_if.tx_data),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .count_o (fifo_count_o),
    .full_o  (fifo_full_o),
    .empty_o (fifo_empty_o)
  );

  assign tx_if.tx_ready = !fifo_full_o;
  assign tx_o           = tx_q;
  assign busy_o         = (state_q != ST_IDLE);

  assign div_last_cfg = (baud_div_i == '0) ? '0 : baud_div_i - DIV_W'(1);
  assign nbits_cfg    = ((data_bits_i == '0) || (data_bits_i > NBW'(DW)))
                        ? NBW'(DW) : data_bits_i;
  assign bit_end      = (baud_cnt_q == div_last_q);
  assign last_data    = (bit_cnt_q == nbits_q - NBW'(1));
  assign can_start    = en_i && !fifo_empty_o;
  assign shift_nxt    = shift_q >> 1;

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q + DIV_W'(1);
    div_last_d = div_last_q;
    bit_cnt_d  = bit_cnt_q;
    nbits_d    = nbits_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    par_en_d   = par_en_q;
    par_odd_d  = par_odd_q;
    two_stop_d = two_stop_q;
    tx_d       = tx_q;
    pop        = 1'b0;
    load       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        baud_cnt_d = '0;
        tx_d       = 1'b1;
        if (can_start) load = 1'b1;
      end
      ST_START: begin
        if (bit_end) begin
          state_d    = ST_DATA;
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
          tx_d       = shift_q[0];
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          baud_cnt_d = '0;
          parity_d   = parity_q ^ shift_q[0];
          if (last_data) begin
            bit_cnt_d = '0;
            if (par_en_q) begin
              state_d = ST_PARITY;
              tx_d    = parity_q ^ shift_q[0] ^ par_odd_q;
            end else begin
              state_d = ST_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + NBW'(1);
            shift_d   = shift_nxt;
            tx_d      = shift_nxt[0];
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_d    = ST_STOP;
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
          tx_d       = 1'b1;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          baud_cnt_d = '0;
          // bit_cnt tracks which stop bit is on the line.
          if (two_stop_q && (bit_cnt_q == '0)) begin
            bit_cnt_d = NBW'(1);
          end else if (can_start) begin
            load = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d    = ST_IDLE;
        baud_cnt_d = '0;
        tx_d       = 1'b1;
      end
    endcase

    // Start a new frame: take the FIFO head and freeze the format for it.
    if (load) begin
      pop        = 1'b1;
      state_d    = ST_START;
      baud_cnt_d = '0;
      bit_cnt_d  = '0;
      shift_d    = fifo_head;
      parity_d   = 1'b0;
      div_last_d = div_last_cfg;
      nbits_d    = nbits_cfg;
      par_en_d   = parity_en_i;
      par_odd_d  = parity_odd_i;
      two_stop_d = two_stop_i;
      tx_d       = 1'b0;
    end

    // Disable aborts the frame in flight; queued bytes stay in the FIFO.
    if (!en_i && (state_q != ST_IDLE)) begin
      state_d    = ST_IDLE;
      baud_cnt_d = '0;
      bit_cnt_d  = '0;
      tx_d       = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      baud_cnt_q <= '0;
      div_last_q <= '0;
      bit_cnt_q  <= '0;
      nbits_q    <= NBW'(DW);
      shift_q    <= '0;
      parity_q   <= 1'b0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      two_stop_q <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      div_last_q <= div_last_d;
      bit_cnt_q  <= bit_cnt_d;
      nbits_q    <= nbits_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      par_en_q   <= par_en_d;
      par_odd_q  <= par_odd_d;
      two_stop_q <= two_stop_d;
      tx_q       <= tx_d;
    end
  end

endmodule
`default_nettype wire
